// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/flag inputs and datapath control outputs of the multicycle control unit
interface multicycle_control_if;
  logic [5:0] Op;
  logic       Zero;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       PCEn;
  logic [3:0] State;
  modport master (
    input  Op, Zero,
    output ALUOp, ALUSrcA, ALUSrcB, IorD, PCSrc, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn, State
  );
  modport slave (
    output Op, Zero,
    input  ALUOp, ALUSrcA, ALUSrcB, IorD, PCSrc, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn, State
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath; MCCTRL_ADDI_EN adds the addi states
module multicycle_control (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic       branch;
  } ctrl_t;
  localparam logic [5:0] LW = 6'b100011;
  state_t state, nxt;
  ctrl_t c;
  function automatic ctrl_t decode(state_t s);
    ctrl_t d = '0;
    case (s)
      FETCH:    begin d.ir_write = 1'b1; d.pc_write = 1'b1; d.alu_src_b = 2'b01; end
      DECODE:   d.alu_src_b = 2'b11;
      MEMADR:   begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      MEMREAD:  d.iord = 1'b1;
      MEMWB:    begin d.mem_to_reg = 1'b1; d.reg_write = 1'b1; end
      MEMWRITE: begin d.iord = 1'b1; d.mem_write = 1'b1; end
      EXECUTE:  begin d.alu_src_a = 1'b1; d.alu_op = 2'b10; end
      ALUWB:    begin d.reg_dst = 1'b1; d.reg_write = 1'b1; end
      BRANCH:   begin d.alu_src_a = 1'b1; d.alu_op = 2'b01; d.pc_src = 2'b01; d.branch = 1'b1; end
`ifdef MCCTRL_ADDI_EN
      ADDIEXEC: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      ADDIWB:   d.reg_write = 1'b1;
`endif
      JUMP:     begin d.pc_src = 2'b10; d.pc_write = 1'b1; end
      default:  d = '0;
    endcase
    return d;
  endfunction
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:    nxt = DECODE;
      DECODE:
        case (bus.Op)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000: nxt = EXECUTE;
          6'b000100: nxt = BRANCH;
`ifdef MCCTRL_ADDI_EN
          6'b001000: nxt = ADDIEXEC;
`endif
          6'b000010: nxt = JUMP;
          default:   nxt = FETCH;
        endcase
      MEMADR:   nxt = bus.Op == LW ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = MEMWB;
      EXECUTE:  nxt = ALUWB;
`ifdef MCCTRL_ADDI_EN
      ADDIEXEC: nxt = ADDIWB;
`endif
      default:  nxt = FETCH;
    endcase
  end
  // outputs are registered alongside the state they decode, so they stay a pure function of state
  always_ff @(posedge clk) begin
    state <= reset ? FETCH : nxt;
    c     <= decode(reset ? FETCH : nxt);
  end
  assign bus.ALUOp    = c.alu_op;
  assign bus.ALUSrcA  = c.alu_src_a;
  assign bus.ALUSrcB  = c.alu_src_b;
  assign bus.IorD     = c.iord;
  assign bus.PCSrc    = c.pc_src;
  assign bus.RegDst   = c.reg_dst;
  assign bus.MemtoReg = c.mem_to_reg;
  assign bus.State    = state;
  // write enables are squashed while reset is held so an aborted instruction leaves no partial write
  assign bus.IRWrite  = c.ir_write & ~reset;
  assign bus.MemWrite = c.mem_write & ~reset;
  assign bus.RegWrite = c.reg_write & ~reset;
  assign bus.PCEn     = (c.pc_write | (c.branch & bus.Zero)) & ~reset;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS datapath, producing the `ALUOp` code that the ALU function decoder consumes together with all datapath enables and mux selects. It is a Moore state machine that steps each instruction through fetch, decode and execution phases. It is driven by the instruction opcode held in the instruction register and by the ALU `Zero` flag. The block sits between the instruction register and the datapath, alongside the ALU function decoder.

## Interface
- No parameters; the opcode width is fixed at 6 and the state width at 4.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `Op` in 6: instruction opcode, `Instr[31:26]`.
- `Zero` in 1: ALU zero flag.
- `ALUOp` out 2: goes to the ALU function decoder. `00` means add, `01` means subtract, `10` means decode funct. `11` is never driven.
- `ALUSrcA` out 1: selects the ALU A input. 0 = PC, 1 = register A.
- `ALUSrcB` out 2: selects the ALU B input. 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `PCSrc` out 2: PC source select. 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `IRWrite` out 1: instruction register write enable.
- `MemWrite` out 1: memory write enable.
- `RegWrite` out 1: register file write enable.
- `RegDst` out 1: destination register select. 0 = rt, 1 = rd.
- `MemtoReg` out 1: register write-back source. 0 = ALUOut, 1 = Data.
- `PCEn` out 1: PC register enable, computed as `PCWrite | (Branch & Zero)`.
- `State` out 4: current state encoding, for debug.

## Operation

**States and encoding**
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Encodings 12–15 are unused. If the state register ever holds one of them, the next state is FETCH and all outputs are 0.

**Transitions**
- FETCH→DECODE.
- From DECODE, the next state depends on `Op`:
  - `100011` (lw) or `101011` (sw) → MEMADR.
  - `000000` (R-type) → EXECUTE.
  - `000100` (beq) → BRANCH.
  - `001000` (addi) → ADDIEXEC.
  - `000010` (j) → JUMP.
  - Any other opcode → FETCH. This is the illegal-opcode path; no write enables are asserted.
- MEMADR→MEMREAD if `Op`=lw, else MEMWRITE.
- MEMREAD→MEMWB.
- EXECUTE→ALUWB.
- ADDIEXEC→ADDIWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP all go to FETCH.

**Outputs**
- Outputs are a pure function of the state register; this is a Moore machine.
- `PCWrite` and `Branch` are internal signals.
- Any output not listed for a state is 0.

| State | Outputs asserted |
|---|---|
| FETCH | `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=01 |
| DECODE | `ALUSrcB`=11 |
| MEMADR | `ALUSrcA`=1, `ALUSrcB`=10 |
| MEMREAD | `IorD`=1 |
| MEMWB | `MemtoReg`=1, `RegWrite`=1 |
| MEMWRITE | `IorD`=1, `MemWrite`=1 |
| EXECUTE | `ALUSrcA`=1, `ALUOp`=10 |
| ALUWB | `RegDst`=1, `RegWrite`=1 |
| BRANCH | `ALUSrcA`=1, `ALUOp`=01, `PCSrc`=01, `Branch`=1 |
| ADDIEXEC | `ALUSrcA`=1, `ALUSrcB`=10 |
| ADDIWB | `RegWrite`=1 |
| JUMP | `PCSrc`=10, `PCWrite`=1 |

## Timing
- There is one state transition per rising edge of `clk`.
- `Op` is sampled in DECODE and MEMADR only. It must be stable from the cycle after FETCH until the instruction returns to FETCH, which the IR guarantees.
- `Zero` is used combinationally, and only in BRANCH, to form `PCEn`.

**Latency per instruction, counted from FETCH entry**

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type | 4 |
| addi | 4 |
| beq | 3 |
| j | 3 |
| illegal opcode | 2 |

**Reset**
- The state after reset is FETCH, so after reset the outputs take the FETCH values: `IRWrite`=1, `PCEn`=1, `ALUSrcB`=01, all others 0, `State`=0.
- In any cycle where `reset`=1, `IRWrite`, `MemWrite`, `RegWrite` and `PCEn` are forced to 0, regardless of state.
- A reset asserted mid-instruction therefore aborts the instruction without a partial write. FETCH is entered on the next edge.
- When `reset` and a would-be transition occur in the same cycle, reset wins.

## Configuration
- Macro: `MCCTRL_ADDI_EN`.
- Defined: addi (`001000`) follows DECODE→ADDIEXEC→ADDIWB→FETCH, with the outputs listed above.
- Undefined:
  - ADDIEXEC and ADDIWB are not implemented.
  - Encodings 9 and 10 are treated like encodings 12–15 (next state FETCH, all outputs 0).
  - `001000` takes the illegal-opcode path (DECODE→FETCH).

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles in EXECUTE → `State`=0 after the edge. During reset cycles `RegWrite`=`MemWrite`=`IRWrite`=`PCEn`=0. After release, FETCH outputs appear with `PCEn`=1.
- **lw:** `Op`=`100011` → `State` sequence 0,1,2,3,4,0. `IorD`=1 in state 3. `RegWrite`=1 and `MemtoReg`=1 only in state 4.
- **sw and R-type:**
  - `Op`=`101011` → sequence 0,1,2,5,0, with `MemWrite`=1 exactly one cycle.
  - `Op`=`000000` → sequence 0,1,6,7,0, with `ALUOp`=10 in state 6 and `RegDst`=1 in state 7.
- **beq:**
  - `Op`=`000100` with `Zero`=1 → `PCEn`=1 and `PCSrc`=01 in state 8.
  - With `Zero`=0 → `PCEn`=0 in state 8.
  - `ALUOp`=01 in both cases.
- **j and illegal:**
  - `Op`=`000010` → sequence 0,1,11,0, with `PCSrc`=10 and `PCEn`=1 in state 11.
  - `Op`=`111111` → sequence 0,1,0, with no write enables asserted in state 1.
- **Macro:** `Op`=`001000` with `MCCTRL_ADDI_EN` defined → sequence 0,1,9,10,0, with `RegWrite`=1 and `RegDst`=0 in state 10. Without the macro → sequence 0,1,0.
